// File: rtl/rd_pkg.sv
// Shared types and balance helper for the multi-lane running-disparity monitor.
package rd_pkg;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } lane_state_t;

   localparam int BAL_POS  = 2;
   localparam int BAL_ZERO = 0;
   localparam int BAL_NEG  = -2;

   // Upper bound on symbol width accepted by balance(); narrower symbols are zero-padded.
   localparam int unsigned MAX_SYM_W = 64;

   // Returns 2*popcount(sym[width-1:0]) - width.
   function automatic int balance(input logic [MAX_SYM_W-1:0] sym, input int unsigned width);
      int unsigned ones;
      ones = 0;
      for (int unsigned i = 0; i < MAX_SYM_W; i++) begin
         if ((i < width) && sym[i]) ones++;
      end
      return (2 * int'(ones)) - int'(width);
   endfunction

endpackage

// File: rtl/rd_lane_monitor.sv
// One lane: running disparity, error pulses, saturating error counter and hunt/locked FSM.
module rd_lane_monitor
   import rd_pkg::*;
#(
   parameter int unsigned SYM_W       = 10,
   parameter int unsigned ERR_CNT_W   = 8,
   parameter int unsigned LOSS_THRESH = 4,
   parameter int unsigned GOOD_THRESH = 16,
   parameter bit          RD_INIT     = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 sym_valid,
   input  logic [SYM_W-1:0]     sym_data,
   input  logic                 err_clr,
   output logic                 rd_out,
   output logic                 disp_err,
   output logic                 illegal_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 lane_locked
);

   localparam int unsigned D_W    = $clog2(SYM_W + 1) + 1;
   localparam int unsigned GOOD_W = 8;
   localparam int unsigned BAD_W  = 4;

   localparam logic signed [D_W-1:0] D_POS  = D_W'(BAL_POS);
   localparam logic signed [D_W-1:0] D_ZERO = D_W'(BAL_ZERO);
   localparam logic signed [D_W-1:0] D_NEG  = D_W'(BAL_NEG);

   logic [MAX_SYM_W-1:0]  sym_ext;
   logic signed [D_W-1:0] d;
   logic                  is_pos, is_zero, is_neg;
   logic                  good, disp_hit, illegal_hit, err;
   logic                  rd_next;
   logic [ERR_CNT_W-1:0]  cnt_next;
   lane_state_t           state, state_next;
   logic [GOOD_W-1:0]     good_run, good_next, good_inc;
   logic [BAD_W-1:0]      bad_cnt, bad_next, bad_inc;

   always_comb begin
      sym_ext = '0;
      sym_ext[SYM_W-1:0] = sym_data;
   end

   assign d = D_W'(balance(sym_ext, SYM_W));

   always_comb begin
      is_pos  = (d == D_POS);
      is_zero = (d == D_ZERO);
      is_neg  = (d == D_NEG);

      good        = sym_valid && (is_zero || (is_pos && !rd_out) || (is_neg && rd_out));
      disp_hit    = sym_valid && ((is_pos && rd_out) || (is_neg && !rd_out));
      illegal_hit = sym_valid && !(is_pos || is_zero || is_neg);
      err         = disp_hit || illegal_hit;

      rd_next = rd_out;
      if (good && !is_zero) rd_next = ~rd_out;

      cnt_next = err_count;
      if (err_clr) begin
         cnt_next = err ? ERR_CNT_W'(1) : '0;
      end else if (err && (err_count != '1)) begin
         cnt_next = err_count + ERR_CNT_W'(1);
      end

      good_inc   = good_run + GOOD_W'(1);
      bad_inc    = bad_cnt + BAD_W'(1);
      state_next = state;
      good_next  = good_run;
      bad_next   = bad_cnt;
      if (err) begin
         good_next = '0;
         if (state == LOCKED) begin
            if (bad_inc == BAD_W'(LOSS_THRESH)) begin
               state_next = HUNT;
               bad_next   = '0;
            end else begin
               bad_next = bad_inc;
            end
         end
      end else if (good) begin
         // Reaching the good threshold locks from HUNT and clears the bad count in LOCKED alike.
         if (good_inc == GOOD_W'(GOOD_THRESH)) begin
            state_next = LOCKED;
            good_next  = '0;
            bad_next   = '0;
         end else begin
            good_next = good_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_out      <= RD_INIT;
         disp_err    <= 1'b0;
         illegal_err <= 1'b0;
         err_count   <= '0;
         state       <= HUNT;
         good_run    <= '0;
         bad_cnt     <= '0;
      end else if (start) begin
         rd_out      <= RD_INIT;
         disp_err    <= 1'b0;
         illegal_err <= 1'b0;
         err_count   <= '0;
         state       <= HUNT;
         good_run    <= '0;
         bad_cnt     <= '0;
      end else begin
         rd_out      <= rd_next;
         disp_err    <= disp_hit;
         illegal_err <= illegal_hit;
         err_count   <= cnt_next;
         state       <= state_next;
         good_run    <= good_next;
         bad_cnt     <= bad_next;
      end
   end

   assign lane_locked = (state == LOCKED);

endmodule

// File: rtl/rd_monitor_multilane.sv
// Multi-lane running-disparity monitor: independent per-lane monitors over sliced buses.
module rd_monitor_multilane
   import rd_pkg::*;
#(
   parameter int unsigned NUM_LANES   = 4,
   parameter int unsigned SYM_W       = 10,
   parameter int unsigned ERR_CNT_W   = 8,
   parameter int unsigned LOSS_THRESH = 4,
   parameter int unsigned GOOD_THRESH = 16,
   parameter bit          RD_INIT     = 1'b0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [NUM_LANES-1:0]           sym_valid,
   input  logic [NUM_LANES*SYM_W-1:0]     sym_data,
   input  logic [NUM_LANES-1:0]           err_clr,
   output logic [NUM_LANES-1:0]           rd_out,
   output logic [NUM_LANES-1:0]           disp_err,
   output logic [NUM_LANES-1:0]           illegal_err,
   output logic [NUM_LANES*ERR_CNT_W-1:0] err_count,
   output logic [NUM_LANES-1:0]           lane_locked
);

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      rd_lane_monitor #(
         .SYM_W      (SYM_W),
         .ERR_CNT_W  (ERR_CNT_W),
         .LOSS_THRESH(LOSS_THRESH),
         .GOOD_THRESH(GOOD_THRESH),
         .RD_INIT    (RD_INIT)
      ) u_lane (
         .clk        (clk),
         .reset      (reset),
         .start      (start),
         .sym_valid  (sym_valid[i]),
         .sym_data   (sym_data[i*SYM_W +: SYM_W]),
         .err_clr    (err_clr[i]),
         .rd_out     (rd_out[i]),
         .disp_err   (disp_err[i]),
         .illegal_err(illegal_err[i]),
         .err_count  (err_count[i*ERR_CNT_W +: ERR_CNT_W]),
         .lane_locked(lane_locked[i])
      );
   end

endmodule

// File: tb/tb_rd_monitor_multilane.sv
// Directed bench for rd_monitor_multilane: default 4-lane instance plus a 1-lane, 3-bit-counter instance.
module tb_rd_monitor_multilane;

   localparam logic [9:0] SYM_P2 = 10'b0000111111;
   localparam logic [9:0] SYM_N2 = 10'b1111000000;
   localparam logic [9:0] SYM_P4 = 10'b0001111111;

   logic        clk, reset, start;
   logic [3:0]  sym_valid, err_clr;
   logic [39:0] sym_data;
   logic [3:0]  rd_out, disp_err, illegal_err, lane_locked;
   logic [31:0] err_count;

   logic        s_start, s_valid, s_clr;
   logic [9:0]  s_data;
   logic        s_rd, s_disp, s_ill, s_lock;
   logic [2:0]  s_cnt;

   int checks   = 0;
   int failures = 0;

   rd_monitor_multilane dut (
      .clk(clk), .reset(reset), .start(start),
      .sym_valid(sym_valid), .sym_data(sym_data), .err_clr(err_clr),
      .rd_out(rd_out), .disp_err(disp_err), .illegal_err(illegal_err),
      .err_count(err_count), .lane_locked(lane_locked)
   );

   rd_monitor_multilane #(.NUM_LANES(1), .ERR_CNT_W(3)) dut_sat (
      .clk(clk), .reset(reset), .start(s_start),
      .sym_valid(s_valid), .sym_data(s_data), .err_clr(s_clr),
      .rd_out(s_rd), .disp_err(s_disp), .illegal_err(s_ill),
      .err_count(s_cnt), .lane_locked(s_lock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int lane, input logic [9:0] data);
      sym_valid[lane] = 1'b1;
      sym_data[lane*10 +: 10] = data;
   endtask

   task automatic idle();
      sym_valid = '0;
      sym_data  = '0;
      err_clr   = '0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      idle();
      s_start = 1'b0; s_valid = 1'b0; s_clr = 1'b0; s_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd", 32'(rd_out), 32'h0);
      check("reset_locked", 32'(lane_locked), 32'h0);
      check("reset_cnt", err_count, 32'h0);
      reset = 1'b0;

      // 1: +2 then -2 on lane 0
      drive(0, SYM_P2); tick();
      check("t1_rd_up", 32'(rd_out), 32'h1);
      check("t1_no_disp", 32'(disp_err), 32'h0);
      check("t1_no_ill", 32'(illegal_err), 32'h0);
      drive(0, SYM_N2); tick();
      check("t1_rd_down", 32'(rd_out), 32'h0);
      idle();

      // 2: -2 at RD=0 on lane 1
      drive(1, SYM_N2); tick();
      check("t2_disp", 32'(disp_err), 32'h2);
      check("t2_rd", 32'(rd_out), 32'h0);
      check("t2_cnt1", 32'(err_count[15:8]), 32'h1);
      idle(); tick();
      check("t2_pulse_end", 32'(disp_err), 32'h0);
      check("t2_cnt_hold", 32'(err_count[15:8]), 32'h1);

      // 3: +4 on lane 2, then clear-with-error, then clear alone
      drive(2, SYM_P4); tick();
      check("t3_ill", 32'(illegal_err), 32'h4);
      check("t3_no_disp", 32'(disp_err), 32'h0);
      check("t3_rd", 32'(rd_out), 32'h0);
      check("t3_cnt1", 32'(err_count[23:16]), 32'h1);
      err_clr[2] = 1'b1; tick();
      check("t3_clr_err", 32'(err_count[23:16]), 32'h1);
      check("t3_ill2", 32'(illegal_err), 32'h4);
      sym_valid = '0; tick();
      check("t3_clr_only", 32'(err_count[23:16]), 32'h0);
      idle();

      // 4: lock lane 3 with 16 good symbols, then lose lock with 4 disparity errors
      for (int k = 0; k < 16; k++) begin
         drive(3, (k % 2 == 0) ? SYM_P2 : SYM_N2);
         tick();
         if (k == 14) check("t4_not_yet", 32'(lane_locked), 32'h0);
      end
      check("t4_locked", 32'(lane_locked), 32'h8);
      for (int k = 0; k < 4; k++) begin
         drive(3, SYM_N2);
         tick();
         if (k == 2) check("t4_still_locked", 32'(lane_locked), 32'h8);
      end
      check("t4_unlocked", 32'(lane_locked), 32'h0);
      check("t4_cnt", 32'(err_count[31:24]), 32'h4);
      check("t4_lane0_cnt", 32'(err_count[7:0]), 32'h0);
      idle();

      // 5: saturation on 3-bit counter
      s_valid = 1'b1; s_data = SYM_P4;
      for (int k = 0; k < 9; k++) begin
         tick();
         if (k == 6) check("t5_cnt7", 32'(s_cnt), 32'h7);
      end
      check("t5_sat", 32'(s_cnt), 32'h7);
      check("t5_ill", 32'(s_ill), 32'h1);
      s_valid = 1'b0;

      // 6: start overrides symbol; then async reset mid-stream
      drive(0, SYM_P2); tick();
      check("t6_rd0_up", 32'(rd_out), 32'h1);
      idle();
      for (int k = 0; k < 16; k++) begin
         drive(3, (k % 2 == 0) ? SYM_P2 : SYM_N2);
         tick();
      end
      check("t6_relock", 32'(lane_locked), 32'h8);
      start = 1'b1;
      for (int ln = 0; ln < 4; ln++) drive(ln, SYM_P2);
      err_clr = 4'hF;
      tick();
      start = 1'b0;
      check("t6_start_rd", 32'(rd_out), 32'h0);
      check("t6_start_locked", 32'(lane_locked), 32'h0);
      check("t6_start_disp", 32'(disp_err), 32'h0);
      check("t6_start_cnt", err_count, 32'h0);
      idle();
      drive(0, SYM_P2); drive(2, SYM_P4); tick();
      check("t6_pre_rd", 32'(rd_out), 32'h1);
      check("t6_pre_ill", 32'(illegal_err), 32'h4);
      check("t6_pre_cnt", err_count, 32'h0001_0000);
      #3 reset = 1'b1;
      #1;
      check("t6_areset_rd", 32'(rd_out), 32'h0);
      check("t6_areset_ill", 32'(illegal_err), 32'h0);
      check("t6_areset_cnt", err_count, 32'h0);
      check("t6_areset_locked", 32'(lane_locked), 32'h0);
      idle();
      tick();
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
